pe_array_sequencer: RTL

Control sequencer that sits directly upstream of the accelerator top level and drives its per-instance control inputs. On a start pulse it sweeps the eight PE columns for each of `num_inst` instances. For every column it issues an MLB read strobe, waits out the PE-array latency, then issues an MLB write strobe. In the same write cycle it emits the accumulator command for `out_acc`. It also presents the running instance index that `sort_relu` uses for ordering.

---
 rtl/pe_array_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pe_array_sequencer.sv
// PE-array column/instance sequencer driving MLB strobes and out_acc commands.
// Optional busy-cycle performance counter enabled by defining SEQ_PERF_CNT_EN.
module pe_array_sequencer #(
    parameter int NUM_COLS = 8,
    parameter int PE_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] num_inst,
    input  logic        hold,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        read_en,
    output logic        write_en,
    output logic [2:0]  col_index,
    output logic [2:0]  acc_sig,
    output logic [31:0] ins_index,
    output logic [31:0] busy_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
    localparam logic [3:0] LAT      = 4'(PE_LAT);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] last_ins;

    function automatic logic [2:0] acc_cmd(input logic [2:0] col);
        logic [2:0] cmd;
        cmd = 3'b001;
        if (col == 3'd0)
            cmd = 3'b010;
        else if (col == LAST_COL)
            cmd = 3'b100;
        return cmd;
    endfunction

    // Strobe/done flops double as "issued" flags: a state leaves only once
    // its pulse was actually presented, so a hold reissues it in full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_en   <= 1'b0;
            write_en  <= 1'b0;
            acc_sig   <= 3'b000;
            col_index <= 3'd0;
            ins_index <= 32'd0;
            wait_cnt  <= 4'd0;
            last_ins  <= 32'd0;
        end else begin
            read_en  <= 1'b0;
            write_en <= 1'b0;
            acc_sig  <= 3'b000;
            done     <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                col_index <= 3'd0;
                ins_index <= 32'd0;
                wait_cnt  <= 4'd0;
            end else if (!hold) begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            busy      <= 1'b1;
                            col_index <= 3'd0;
                            ins_index <= 32'd0;
                            last_ins  <= num_inst - 32'd1;
                            if (num_inst != 32'd0) begin
                                state   <= READ;
                                read_en <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (read_en) begin
                            state    <= EXEC;
                            wait_cnt <= LAT;
                        end else begin
                            read_en <= 1'b1;
                        end
                    end
                    EXEC: begin
                        if (wait_cnt <= 4'd1) begin
                            state    <= WRITE;
                            write_en <= 1'b1;
                            acc_sig  <= acc_cmd(col_index);
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    WRITE: begin
                        if (!write_en) begin
                            write_en <= 1'b1;
                            acc_sig  <= acc_cmd(col_index);
                        end else if (col_index != LAST_COL) begin
                            col_index <= col_index + 3'd1;
                            state     <= READ;
                            read_en   <= 1'b1;
                        end else if (ins_index < last_ins) begin
                            col_index <= 3'd0;
                            ins_index <= ins_index + 32'd1;
                            state     <= READ;
                            read_en   <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic accept;
    assign accept = (state == IDLE) && start && !abort && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_cycles <= 32'd0;
        else if (accept)
            busy_cycles <= 32'd0;
        else if (busy && busy_cycles != 32'hFFFF_FFFF)
            busy_cycles <= busy_cycles + 32'd1;
    end
`else
    assign busy_cycles = 32'd0;
`endif

endmodule
